// File: rtl/acc_uart_tx.sv
// acc_uart_tx: snapshots the accumulator total on start and streams it as UART 8N1, MSB byte first.
module acc_uart_tx #(
  parameter int CLK_DIV = 434,
  parameter int WIDTH   = 128
) (
  input  logic             clk,
  input  logic             nRst,
  input  logic             start_i,
  input  logic [WIDTH-1:0] big_i,
  output logic             tx_o,
  output logic             busy_o,
  output logic             done_o
);
  localparam int BYTES = WIDTH / 8;
  localparam int BW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  localparam int YW = BYTES > 1 ? $clog2(BYTES) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLK_DIV - 1);
  localparam logic [YW-1:0] BYTE_LAST = YW'(BYTES - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] snap_q, snap_d, snap_sh;
  logic [BW-1:0]    baud_q, baud_d;
  logic [2:0]       bit_q, bit_d;
  logic [YW-1:0]    byte_q, byte_d;
  logic             tx_q, tx_d, busy_q, busy_d, done_q, done_d;
  logic             baud_end;
  logic [7:0]       cur_byte;

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state_q <= IDLE;
      snap_q  <= '0;
      baud_q  <= '0;
      bit_q   <= '0;
      byte_q  <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      snap_q  <= snap_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    snap_d   = snap_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    byte_d   = byte_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    baud_end = baud_q == BAUD_LAST;
    if (state_q != IDLE) baud_d = baud_end ? '0 : baud_q + 1'b1;
    case (state_q)
      IDLE: if (start_i) begin
        snap_d  = big_i;
        byte_d  = '0;
        baud_d  = '0;
        state_d = START;
        busy_d  = 1'b1;
      end
      START: if (baud_end) begin
        state_d = DATA;
        bit_d   = '0;
      end
      DATA: if (baud_end) begin
        state_d = bit_q == 3'd7 ? STOP : DATA;
        bit_d   = bit_q == 3'd7 ? 3'd0 : bit_q + 3'd1;
      end
      STOP: if (baud_end) begin
        if (byte_q == BYTE_LAST) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          state_d = START;
          byte_d  = byte_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    // tx is registered, so it is derived from the state being entered
    snap_sh  = snap_d << (8 * byte_d);
    cur_byte = snap_sh[WIDTH-1 -: 8];
    tx_d     = state_d == START ? 1'b0 : state_d == DATA ? cur_byte[bit_d] : 1'b1;
  end

  assign tx_o   = tx_q;
  assign busy_o = busy_q;
  assign done_o = done_q;
endmodule
